// File: rtl/weight_mac_sequencer.sv
// Weight BRAM controller for one neuron: streams a weight vector into the BRAM
// (load mode) or accumulates the signed dot product with the input BRAM (compute mode).
module weight_mac_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int ACCW  = 37
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            LOAD,
    input  logic [DW-1:0]   LD_DATA,
    input  logic            LD_VALID,
    output logic [AW-1:0]   W_ADDR,
    output logic            W_EN,
    output logic            W_WE,
    output logic [DW-1:0]   W_DI,
    input  logic [DW-1:0]   W_DO,
    output logic [AW-1:0]   X_ADDR,
    output logic            X_EN,
    input  logic [DW-1:0]   X_DO,
    output logic            BUSY,
    output logic            DONE,
    output logic            LOAD_DONE,
    output logic [ACCW-1:0] ACC_OUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST_ADDR = AW'(DEPTH - 2);

    state_t            state_r;
    logic [AW-1:0]     w_addr_r;
    logic [AW-1:0]     x_addr_r;
    logic [AW-1:0]     ptr_r;
    logic              w_en_r;
    logic              w_we_r;
    logic              x_en_r;
    logic [DW-1:0]     w_di_r;
    logic              busy_r;
    logic              done_r;
    logic              load_done_r;
    logic [ACCW-1:0]   acc_r;
    logic [ACCW-1:0]   acc_out_r;
    logic [ACCW-1:0]   acc_next_s;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic [ACCW-1:0] sext_product(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return {{(ACCW - 2*DW){p[2*DW-1]}}, p};
    endfunction

    // Running sum including the product the BRAMs presented at the last negedge.
    always_comb begin
        acc_next_s = acc_r + sext_product(W_DO, X_DO);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            w_addr_r    <= '0;
            x_addr_r    <= '0;
            ptr_r       <= '0;
            w_en_r      <= 1'b0;
            w_we_r      <= 1'b0;
            x_en_r      <= 1'b0;
            w_di_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            load_done_r <= 1'b0;
            acc_r       <= '0;
            acc_out_r   <= '0;
        end else begin
            done_r      <= 1'b0;
            load_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    w_we_r <= 1'b0;
                    if (START) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        w_addr_r <= '0;
                        x_addr_r <= '0;
                        w_en_r   <= 1'b1;
                        x_en_r   <= 1'b1;
                        acc_r    <= '0;
                    end else if (LOAD) begin
                        state_r <= WRITE;
                        busy_r  <= 1'b1;
                        ptr_r   <= '0;
                        w_en_r  <= 1'b0;
                        x_en_r  <= 1'b0;
                    end else begin
                        w_en_r <= 1'b0;
                        x_en_r <= 1'b0;
                    end
                end
                // Address k is issued while the product of address k-1 is accumulated.
                RUN: begin
                    acc_r    <= acc_next_s;
                    w_addr_r <= x_addr_r + AW'(1);
                    x_addr_r <= x_addr_r + AW'(1);
                    if (x_addr_r == PRE_LAST_ADDR) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    acc_r     <= acc_next_s;
                    acc_out_r <= acc_next_s;
                    done_r    <= 1'b1;
                    w_en_r    <= 1'b0;
                    x_en_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                // LOAD_DONE being high marks the cycle after the final word was accepted.
                WRITE: begin
                    if (load_done_r) begin
                        w_en_r  <= 1'b0;
                        w_we_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (LD_VALID) begin
                        w_addr_r <= ptr_r;
                        w_di_r   <= LD_DATA;
                        w_en_r   <= 1'b1;
                        w_we_r   <= 1'b1;
                        if (ptr_r == LAST_ADDR) begin
                            load_done_r <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + AW'(1);
                        end
                    end else begin
                        w_en_r <= 1'b0;
                        w_we_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    w_en_r  <= 1'b0;
                    w_we_r  <= 1'b0;
                    x_en_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign W_ADDR    = w_addr_r;
    assign W_EN      = w_en_r;
    assign W_WE      = w_we_r;
    assign W_DI      = w_di_r;
    assign X_ADDR    = x_addr_r;
    assign X_EN      = x_en_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign LOAD_DONE = load_done_r;
    assign ACC_OUT   = acc_out_r;

endmodule

// File: tb/tb_weight_mac_sequencer.sv
// Scoreboard bench for weight_mac_sequencer: behavioural BRAM models, a dot-product
// reference model, and a monitor that checks each DONE against queued expectations.
module tb_weight_mac_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int ACCW  = 37;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            START = 1'b0;
    logic            LOAD = 1'b0;
    logic [DW-1:0]   LD_DATA = '0;
    logic            LD_VALID = 1'b0;
    logic [AW-1:0]   W_ADDR;
    logic            W_EN;
    logic            W_WE;
    logic [DW-1:0]   W_DI;
    logic [DW-1:0]   W_DO = '0;
    logic [AW-1:0]   X_ADDR;
    logic            X_EN;
    logic [DW-1:0]   X_DO = '0;
    logic            BUSY;
    logic            DONE;
    logic            LOAD_DONE;
    logic [ACCW-1:0] ACC_OUT;

    weight_mac_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LOAD(LOAD),
        .LD_DATA(LD_DATA), .LD_VALID(LD_VALID),
        .W_ADDR(W_ADDR), .W_EN(W_EN), .W_WE(W_WE), .W_DI(W_DI), .W_DO(W_DO),
        .X_ADDR(X_ADDR), .X_EN(X_EN), .X_DO(X_DO),
        .BUSY(BUSY), .DONE(DONE), .LOAD_DONE(LOAD_DONE), .ACC_OUT(ACC_OUT)
    );

    always #5 CLK = ~CLK;

    // Negedge-clocked BRAMs with registered DO; weight BRAM is write-first.
    logic [DW-1:0] w_mem [32];
    shortint       x_mem [32];

    always @(negedge CLK) begin
        if (W_EN) begin
            if (W_WE) begin
                w_mem[W_ADDR] <= W_DI;
                W_DO          <= W_DI;
            end else begin
                W_DO <= w_mem[W_ADDR];
            end
        end
    end

    always @(negedge CLK) begin
        if (X_EN) X_DO <= x_mem[X_ADDR];
    end

    typedef struct {
        longint acc;
        int     done_cyc;
    } exp_t;

    exp_t    sb_q[$];
    shortint ref_w[DEPTH];
    shortint ld_vals[DEPTH];
    int      checks = 0;
    int      fails = 0;
    int      cyc = 0;
    int      we_cnt = 0;
    int      ld_cnt = 0;
    int      ld_cyc = -1;
    int      viol = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: pops the scoreboard on every DONE and tracks write/load activity.
    initial begin
        int   streak;
        exp_t e;
        streak = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                streak = 0;
            end else begin
                if (W_EN && W_WE) we_cnt++;
                if (W_WE && X_EN) viol++;
                if (X_EN && (!W_EN || (W_ADDR != X_ADDR))) viol++;
                if (LOAD_DONE) begin
                    ld_cnt++;
                    ld_cyc = cyc;
                end
                if (DONE) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: DONE with empty scoreboard, ACC_OUT=%0d", $signed(ACC_OUT));
                    end else begin
                        e = sb_q.pop_front();
                        check("acc_out", longint'($signed(ACC_OUT)), e.acc);
                        check("done_latency", cyc, e.done_cyc);
                        check("busy_cycles", streak, DEPTH);
                    end
                end
                if (BUSY) streak++;
                else streak = 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!BUSY && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: BUSY=%0d pending=%0d after 200 cycles", name, BUSY, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        START = 1'b0;
        LOAD = 1'b0;
        LD_VALID = 1'b0;
        @(negedge CLK);
        check("rst_busy", longint'(BUSY), 0);
        check("rst_done", longint'(DONE), 0);
        check("rst_load_done", longint'(LOAD_DONE), 0);
        check("rst_w_en_we_x_en", longint'({W_EN, W_WE, X_EN}), 0);
        check("rst_acc_out", longint'($signed(ACC_OUT)), 0);
        sb_q.delete();
        tick();
        RST_N = 1'b1;
        tick();
        check("post_rst_acc_out", longint'($signed(ACC_OUT)), 0);
    endtask

    // gap_mode: 0 none, 1 one idle cycle before every word, 2 random gaps.
    task automatic load_vec(input int n, input int gap_mode, input bit start_in_gap);
        int ld0;
        int we0;
        int exp_cyc;
        int ngap;
        ld0 = ld_cnt;
        LD_VALID = 1'b1;
        LD_DATA = 16'hDEAD;
        tick();
        tick();
        LD_VALID = 1'b0;
        we0 = we_cnt;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        exp_cyc = -1;
        for (int k = 0; k < n; k++) begin
            ngap = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            for (int g = 0; g < ngap; g++) begin
                LD_VALID = 1'b0;
                START = (start_in_gap && k == 5) ? 1'b1 : 1'b0;
                tick();
                START = 1'b0;
            end
            LD_VALID = 1'b1;
            LD_DATA = ld_vals[k];
            tick();
            ref_w[k] = ld_vals[k];
            exp_cyc = cyc;
        end
        LD_VALID = 1'b0;
        if (n < DEPTH) begin
            tick();
            do_reset();
            check("abort_no_load_done", ld_cnt - ld0, 0);
            check("abort_words_written", we_cnt - we0, n);
        end else begin
            wait_idle("load");
            check("load_done_count", ld_cnt - ld0, 1);
            check("load_done_cycle", ld_cyc, exp_cyc);
            check("words_written", we_cnt - we0, n);
        end
    endtask

    function automatic longint model_dot();
        longint s;
        s = 0;
        for (int k = 0; k < DEPTH; k++) s += longint'(ref_w[k]) * longint'(x_mem[k]);
        return s;
    endfunction

    task automatic issue_start(input bit with_load);
        exp_t e;
        e.acc = model_dot();
        e.done_cyc = cyc + 1 + DEPTH;
        sb_q.push_back(e);
        START = 1'b1;
        LOAD = with_load;
        tick();
        START = 1'b0;
        LOAD = 1'b0;
    endtask

    task automatic run_dot(input bit with_load);
        int we0;
        we0 = we_cnt;
        issue_start(with_load);
        wait_idle("run");
        check("no_writes_in_run", we_cnt - we0, 0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) x_mem[k] = 16'sd0;
        for (int k = 0; k < DEPTH; k++) ref_w[k] = 16'sd0;
        tick();
        do_reset();

        for (int k = 0; k < DEPTH; k++) begin
            ld_vals[k] = shortint'(k + 1);
            x_mem[k] = 16'sd2;
        end
        load_vec(DEPTH, 0, 1'b0);
        run_dot(1'b0);

        for (int k = 0; k < DEPTH; k++) begin
            ld_vals[k] = -16'sd1;
            x_mem[k] = 16'sh7FFF;
        end
        load_vec(DEPTH, 1, 1'b0);
        run_dot(1'b0);

        for (int k = 0; k < DEPTH; k++) begin
            ld_vals[k] = -16'sd32768;
            x_mem[k] = -16'sd32768;
        end
        load_vec(DEPTH, 0, 1'b0);
        run_dot(1'b0);

        for (int k = 0; k < DEPTH; k++) begin
            ld_vals[k] = shortint'($urandom);
            x_mem[k] = 16'sd1;
        end
        load_vec(DEPTH, 1, 1'b1);
        run_dot(1'b0);

        for (int k = 0; k < DEPTH; k++) x_mem[k] = shortint'($urandom);
        run_dot(1'b1);

        issue_start(1'b0);
        repeat (10) tick();
        do_reset();
        check("no_done_after_abort", sb_q.size(), 0);
        run_dot(1'b0);

        for (int k = 0; k < DEPTH; k++) begin
            ld_vals[k] = shortint'($urandom);
            x_mem[k] = 16'sd1;
        end
        load_vec(12, 0, 1'b0);
        run_dot(1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                ld_vals[k] = shortint'($urandom);
                x_mem[k] = shortint'($urandom);
            end
            load_vec(DEPTH, 2, 1'b0);
            run_dot(1'b0);
        end

        repeat (3) tick();
        check("lockstep_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
